// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter for the shared 8:1 mux. It grants one requester at a time,
// drives the mux select lines, and uses a hold timeout to bound each tenure.
module mux8_rr_arbiter #(
    parameter int NREQ     = 8,
    parameter int SELW     = 3,
    parameter int MAX_HOLD = 4,
    parameter int CNTW     = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            done,
    output logic [NREQ-1:0] grant,
    output logic [SELW-1:0] select,
    output logic            busy,
    output logic            preempt
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state, state_nxt;
    logic [SELW-1:0] ptr, ptr_nxt;
    logic [CNTW-1:0] hold_cnt, hold_cnt_nxt;
    logic [NREQ-1:0] grant_nxt;
    logic [SELW-1:0] select_nxt;
    logic            preempt_nxt;

    logic            found;
    logic [SELW-1:0] winner;
    logic [SELW-1:0] idx;
    logic            timeout;
    logic            release_now;

    // Search starts just past the last winner, so the last winner ranks lowest.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = ptr + SELW'(i);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign timeout     = (MAX_HOLD != 0) && (hold_cnt == CNTW'(MAX_HOLD));
    assign release_now = done || !req[select] || timeout;

    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        hold_cnt_nxt = hold_cnt;
        grant_nxt    = grant;
        select_nxt   = select;
        preempt_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt    = GRANT;
                    ptr_nxt      = winner;
                    hold_cnt_nxt = CNTW'(1);
                    grant_nxt    = NREQ'(1) << winner;
                    select_nxt   = winner;
                end
            end
            GRANT: begin
                if (release_now) begin
                    preempt_nxt = timeout && !done && req[select];
                    if (found) begin
                        ptr_nxt      = winner;
                        hold_cnt_nxt = CNTW'(1);
                        grant_nxt    = NREQ'(1) << winner;
                        select_nxt   = winner;
                    end else begin
                        state_nxt    = IDLE;
                        hold_cnt_nxt = '0;
                        grant_nxt    = '0;
                    end
                end else if (hold_cnt != {CNTW{1'b1}}) begin
                    hold_cnt_nxt = hold_cnt + CNTW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= SELW'(NREQ - 1);
            hold_cnt <= '0;
            grant    <= '0;
            select   <= '0;
            preempt  <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            hold_cnt <= hold_cnt_nxt;
            grant    <= grant_nxt;
            select   <= select_nxt;
            preempt  <= preempt_nxt;
        end
    end

    assign busy = (state == GRANT);

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Self-checking bench for mux8_rr_arbiter: a directed vector table, followed by
// hand-written sequences for the timeout, coincident-release and reset corners.
module tb_mux8_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic [2:0] select;
    logic       busy;
    logic       preempt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst_n;
        logic [7:0] req;
        logic       done;
        logic [7:0] exp_grant;
        logic [2:0] exp_select;
        logic       exp_busy;
        logic       exp_preempt;
    } vec_t;

    vec_t vecs[$];

    mux8_rr_arbiter #(
        .NREQ(8), .SELW(3), .MAX_HOLD(4), .CNTW(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .done(done),
        .grant(grant),
        .select(select),
        .busy(busy),
        .preempt(preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
    task automatic applyStimulus(input logic r, input logic [7:0] q, input logic d);
        @(negedge clk);
        rst_n = r;
        req   = q;
        done  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] eg, input logic [2:0] es,
                               input logic eb, input logic ep);
        checks++;
        if (grant !== eg || select !== es || busy !== eb || preempt !== ep) begin
            errors++;
            $display("[TB] FAIL %s: got grant=%h select=%0d busy=%b preempt=%b, want grant=%h select=%0d busy=%b preempt=%b",
                     name, grant, select, busy, preempt, eg, es, eb, ep);
        end
    endtask

    function automatic void addVec(input logic r, input logic [7:0] q, input logic d,
                                   input logic [7:0] eg, input logic [2:0] es,
                                   input logic eb, input logic ep);
        vec_t v;
        v.rst_n = r; v.req = q; v.done = d;
        v.exp_grant = eg; v.exp_select = es; v.exp_busy = eb; v.exp_preempt = ep;
        vecs.push_back(v);
    endfunction

    initial begin
        rst_n = 1'b0;
        req   = '0;
        done  = 1'b0;

        // Single request, grant, then release on done with no other requesters.
        addVec(0, 8'h00, 0, 8'h00, 3'd0, 0, 0);
        addVec(1, 8'h00, 1, 8'h00, 3'd0, 0, 0);
        addVec(1, 8'h01, 0, 8'h01, 3'd0, 1, 0);
        addVec(1, 8'h00, 1, 8'h00, 3'd0, 0, 0);
        // All requesting with done every cycle: full rotation, no idle gaps.
        addVec(0, 8'h00, 0, 8'h00, 3'd0, 0, 0);
        addVec(1, 8'hFF, 1, 8'h01, 3'd0, 1, 0);
        for (int i = 1; i < 8; i++)
            addVec(1, 8'hFF, 1, 8'h01 << i, 3'(i), 1, 0);
        addVec(1, 8'hFF, 1, 8'h01, 3'd0, 1, 0);
        addVec(1, 8'h00, 0, 8'h00, 3'd0, 0, 0);
        // Grantee withdraws, handoff to 5, then everyone withdraws.
        addVec(0, 8'h00, 0, 8'h00, 3'd0, 0, 0);
        addVec(1, 8'h24, 0, 8'h04, 3'd2, 1, 0);
        addVec(1, 8'h20, 0, 8'h20, 3'd5, 1, 0);
        addVec(1, 8'h00, 0, 8'h00, 3'd5, 0, 0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst_n, vecs[i].req, vecs[i].done);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_grant, vecs[i].exp_select,
                        vecs[i].exp_busy, vecs[i].exp_preempt);
        end

        // Timeout rotation between requesters 0 and 7.
        applyStimulus(0, 8'h00, 0);
        applyStimulus(1, 8'h81, 0);
        checkOutput("to_first", 8'h01, 3'd0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 8'h81, 0);
            checkOutput($sformatf("to_hold0_%0d", i), 8'h01, 3'd0, 1, 0);
        end
        applyStimulus(1, 8'h81, 0);
        checkOutput("to_preempt7", 8'h80, 3'd7, 1, 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 8'h81, 0);
            checkOutput($sformatf("to_hold7_%0d", i), 8'h80, 3'd7, 1, 0);
        end
        applyStimulus(1, 8'h81, 0);
        checkOutput("to_back0", 8'h01, 3'd0, 1, 1);

        // Timeout coinciding with done must not flag preempt.
        applyStimulus(0, 8'h00, 0);
        applyStimulus(1, 8'h03, 0);
        checkOutput("co_first", 8'h01, 3'd0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 8'h03, 0);
            checkOutput($sformatf("co_hold_%0d", i), 8'h01, 3'd0, 1, 0);
        end
        applyStimulus(1, 8'h03, 1);
        checkOutput("co_handoff", 8'h02, 3'd1, 1, 0);

        // Reset mid-grant, then regrant, then confirm the pointer was restored.
        applyStimulus(0, 8'h00, 0);
        applyStimulus(1, 8'h10, 0);
        checkOutput("rs_grant4", 8'h10, 3'd4, 1, 0);
        applyStimulus(0, 8'h10, 0);
        checkOutput("rs_drop", 8'h00, 3'd0, 0, 0);
        applyStimulus(1, 8'h10, 0);
        checkOutput("rs_regrant4", 8'h10, 3'd4, 1, 0);
        applyStimulus(1, 8'h01, 0);
        checkOutput("rs_grant0", 8'h01, 3'd0, 1, 0);
        applyStimulus(0, 8'h00, 0);
        applyStimulus(1, 8'h03, 0);
        checkOutput("rs_ptr_reset", 8'h01, 3'd0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
